// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control slice.
//   pipe_state_t : hazard controller FSM encoding (RUN / KILL)
//   REG_ZERO     : architectural zero register, never a hazard source
//   sat_inc      : saturating increment used by the performance counters
package pipe_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    KILL = 1'b1
  } pipe_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Increment v unless it already equals max. Operates on a 32-bit
  // container so any counter of width <= 32 can share it.
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic [31:0] max);
    return (v == max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives ID/EX hazard sources, consumes controls
//   slave  : hazard_ctrl side
// Signals: id_rs1/id_rs2/id_use_rs1/id_use_rs2, ex_mem_read/ex_reg_write/
// ex_write_addr, ex_branch_taken, id_jump (to controller); pc_write,
// ifid_write, ifid_flush, idex_flush, hazard_a, hazard_b, stall_count,
// flush_count, dbg_state, dbg_kill_cnt (from controller).
// There is no valid/ready handshake here: every signal is a level that is
// meaningful in every cycle, and the controls respond combinationally.
interface hazard_ctrl_if
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_mem_read;
  logic             ex_reg_write;
  logic [4:0]       ex_write_addr;
  logic             ex_branch_taken;
  logic             id_jump;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             hazard_a;
  logic             hazard_b;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  pipe_state_t      dbg_state;
  logic [2:0]       dbg_kill_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read,
           ex_reg_write, ex_write_addr, ex_branch_taken, id_jump,
    input  pc_write, ifid_write, ifid_flush, idex_flush, hazard_a,
           hazard_b, stall_count, flush_count, dbg_state, dbg_kill_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read,
           ex_reg_write, ex_write_addr, ex_branch_taken, id_jump,
    output pc_write, ifid_write, ifid_flush, idex_flush, hazard_a,
           hazard_b, stall_count, flush_count, dbg_state, dbg_kill_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc = 1, sticks at 2^W-1.
//   clock : rising-edge clock
//   reset : synchronous active-high clear
//   inc   : count enable
//   count : current value
module sat_counter
  import pipe_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  localparam logic [31:0] MAX = 32'({W{1'b1}});

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= W'(sat_inc(32'(count), MAX));
    end
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and flush controller for the ID/EX pipeline register.
// Detects load-use hazards (one-cycle bubble), kills wrong-path work after a
// taken branch in EX (BRANCH_PENALTY cycles) or a jump in ID (one cycle),
// and keeps saturating stall/flush event counters.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : hazard sources in, pipeline controls and counters out
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int BRANCH_PENALTY = 1,
  parameter int CNT_W          = 16
) (
  input  logic          clock,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);
  // The branch cycle itself is the first flushed cycle; KILL covers the
  // remaining BRANCH_PENALTY-1 cycles, so the counter starts at PENALTY-2.
  localparam logic [2:0] KILL_INIT =
    3'((BRANCH_PENALTY > 1) ? BRANCH_PENALTY - 2 : 0);

  pipe_state_t state;
  logic [2:0]  kill_cnt;
  logic        ld, ha, hb;
  logic        stall_inc, flush_inc;

  assign ld = bus.ex_mem_read & bus.ex_reg_write &
              (bus.ex_write_addr != REG_ZERO);
  assign ha = ld & bus.id_use_rs1 & (bus.id_rs1 == bus.ex_write_addr);
  assign hb = ld & bus.id_use_rs2 & (bus.id_rs2 == bus.ex_write_addr);

  // Priority: branch > KILL > load-use > jump > normal run.
  always_comb begin
    bus.pc_write   = 1'b1;
    bus.ifid_write = 1'b1;
    bus.ifid_flush = 1'b0;
    bus.idex_flush = 1'b0;
    bus.hazard_a   = 1'b0;
    bus.hazard_b   = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    if (reset) begin
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (bus.ex_branch_taken) begin
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
      flush_inc      = 1'b1;
    end else if (state == KILL) begin
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (ha | hb) begin
      // Freeze PC and IF/ID, bubble into ID/EX; a pending jump waits.
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
      bus.idex_flush = 1'b1;
      bus.hazard_a   = ha;
      bus.hazard_b   = hb;
      stall_inc      = 1'b1;
    end else if (bus.id_jump) begin
      bus.ifid_flush = 1'b1;
      flush_inc      = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RUN;
      kill_cnt <= 3'd0;
    end else if (bus.ex_branch_taken) begin
      // A branch while already killing restarts the window.
      state    <= (BRANCH_PENALTY > 1) ? KILL : RUN;
      kill_cnt <= KILL_INIT;
    end else if (state == KILL) begin
      if (kill_cnt == 3'd0) begin
        state <= RUN;
      end else begin
        kill_cnt <= kill_cnt - 3'd1;
      end
    end
  end

  assign bus.dbg_state    = state;
  assign bus.dbg_kill_cnt = kill_cnt;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_inc),
    .count (bus.stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (flush_inc),
    .count (bus.flush_count)
  );
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and flush controller that drives the ID/EX pipeline register from the control side.
- Detects load-use hazards between the instruction in ID and the load in EX, and inserts bubbles.
- Kills wrong-path instructions after a taken branch in EX or a jump in ID.
- Freezes the PC and IF/ID register when needed, and keeps saturating stall and flush performance counters.

Parameters:
- BRANCH_PENALTY, 1: total cycles IF/ID and ID/EX are flushed per taken branch (valid range 1..7).
- CNT_W, 16: width of the stall_count and flush_count counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs1  in  5  rs field of the instruction in ID.
- id_rs2  in  5  rt field of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  mem_read output of the ID/EX register.
- ex_reg_write  in  1  reg_write output of the ID/EX register.
- ex_write_addr  in  5  write_addr output of the ID/EX register.
- ex_branch_taken  in  1  branch in EX resolved taken this cycle.
- id_jump  in  1  jump decoded in ID.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID clear (inserts NOP).
- idex_flush  out  1  drives the ID/EX flush input; 1 zeroes its controls.
- hazard_a  out  1  load-use hazard on rs1; presented to ID/EX hazardA.
- hazard_b  out  1  load-use hazard on rs2; presented to ID/EX hazardB.
- stall_count  out  CNT_W  load-use bubbles inserted since reset.
- flush_count  out  CNT_W  branch/jump flush events since reset.

Behaviour:
- Clocking: one clock domain. Reset is synchronous and active-high.
- Reset state: FSM enters RUN, kill counter = 0, stall_count = 0, flush_count = 0.
- Outputs while reset = 1: pc_write = 0, ifid_write = 0, ifid_flush = 1, idex_flush = 1, hazard_a = 0, hazard_b = 0.
- Control outputs are combinational from state and inputs, with zero-cycle latency. Counters and state update on the rising edge.
- Hazard terms:
  - ld = ex_mem_read & ex_reg_write & (ex_write_addr != 0).
  - ha = ld & id_use_rs1 & (id_rs1 == ex_write_addr).
  - hb = ld & id_use_rs2 & (id_rs2 == ex_write_addr).
  - Register 0 never causes a hazard.
- FSM states: RUN and KILL. Kill counter is 3 bits.
- Priority within a cycle, highest first: ex_branch_taken, then KILL, then load-use, then id_jump.
- ex_branch_taken = 1 (any state):
  - pc_write = 1, ifid_write = 1, ifid_flush = 1, idex_flush = 1, hazard_a/b = 0.
  - flush_count increments.
  - If BRANCH_PENALTY > 1, next state is KILL with counter = BRANCH_PENALTY-2; otherwise next state is RUN.
  - A branch arriving while in KILL restarts the counter.
- KILL (no branch this cycle):
  - pc_write = 1, ifid_write = 1, ifid_flush = 1, idex_flush = 1.
  - When counter = 0, next state is RUN; otherwise the counter decrements.
  - Load-use and jump are ignored in KILL; no counter increments.
- RUN with (ha | hb), no branch:
  - Stall: pc_write = 0, ifid_write = 0, ifid_flush = 0, idex_flush = 1, hazard_a = ha, hazard_b = hb.
  - stall_count increments. State stays RUN.
  - The bubble clears ex_mem_read in the next cycle, so the stall lasts exactly one cycle per load.
  - id_jump is suppressed while stalled; it is re-evaluated next cycle.
- RUN with id_jump, no hazard:
  - pc_write = 1, ifid_write = 1, ifid_flush = 1, idex_flush = 0.
  - flush_count increments.
- RUN otherwise: pc_write = 1, ifid_write = 1, ifid_flush = 0, idex_flush = 0, hazard_a/b = 0.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset mid-KILL or mid-stall: FSM returns to RUN next cycle and all pending kills are dropped.

Decomposition:
- Shared package pipe_pkg holds:
  - FSM state encoding (RUN = 1'b0, KILL = 1'b1).
  - REG_ZERO = 5'd0.
  - Reusable sat_inc function for saturating counters.
- One sub-module, sat_counter (params W; ports clock, reset, inc, count), instantiated twice for stall_count and flush_count.
- All other logic lives in hazard_ctrl.

Test Plan:
- Load-use on rs1: ex_mem_read = 1, ex_reg_write = 1, ex_write_addr = 5, id_rs1 = 5, id_use_rs1 = 1 -> same cycle pc_write = 0, ifid_write = 0, idex_flush = 1, hazard_a = 1, hazard_b = 0; stall_count 0 -> 1. Next cycle with ex_mem_read = 0 -> normal RUN outputs.
- Register-zero and unused operand: ex_write_addr = 0 with id_rs1 = 0 -> no stall. ex_write_addr = 7 with id_rs2 = 7 but id_use_rs2 = 0 -> no stall.
- Branch with BRANCH_PENALTY = 3: pulse ex_branch_taken for 1 cycle -> ifid_flush and idex_flush high for exactly 3 cycles, pc_write = 1 throughout, flush_count = 1. A load-use match during cycles 2-3 gives no stall and stall_count stays 0.
- Simultaneous events: ex_branch_taken = 1 together with a load-use match and id_jump = 1 -> branch outputs only; flush_count +1, stall_count +0.
- Reset mid-KILL: reset = 1 in the 2nd kill cycle -> outputs take reset values, both counters become 0, and after reset deasserts the FSM is in RUN with no further flushes.
- Saturation with CNT_W = 2: 5 load-use stalls -> stall_count reads 1, 2, 3, 3, 3.
